// File: rtl/sipo_piso_pkg.sv
// Shared definitions for the serial link endpoints (SIPO receiver / PISO shifter).
// Holds the bit-order encoding both ends agree on and the receiver FSM states.
package sipo_piso_pkg;

    // Bit-order encoding: LSB_FIRST puts the first serial bit in word bit 0.
    localparam int unsigned LSB_FIRST = 32'd0;
    localparam int unsigned MSB_FIRST = 32'd1;

    // Receiver framing state: IDLE means no partial word is held.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register for the SIPO receiver: presents completed words on a
// valid/ready interface and flags words lost because the register was full.
module sipo_hold_reg
    import sipo_piso_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             dout_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic accept_s;
    logic drop_s;

    // Decide whether a completing word is loaded or dropped; a transfer on the
    // same edge frees the register, so the new word is still accepted.
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (word_done) begin
            if (!dout_valid || dout_ready) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Holding register, valid flag and sticky overrun (set dominates clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= {WIDTH{1'b0}};
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept_s) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= dout_valid;
            end

            if (drop_s) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver. Samples ser on every clk edge where
// shift_en is high, assembles WIDTH-bit words in the configured bit order and
// hands them to a valid/ready holding register. sync realigns the framing.
module sipo_rx
    import sipo_piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 32'd8,
    parameter int unsigned MSB_FIRST = LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser,
    input  logic             shift_en,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned     CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(WIDTH - 32'd1);
    localparam logic [CW-1:0]   ONE_CNT   = CW'(32'd1);
    localparam bit              MSB_ORDER = (MSB_FIRST != LSB_FIRST);

    state_e           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    bit_cnt_r;

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] fresh_s;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic             word_done_s;

    // Shift the current ser bit in at the end that matches the bit order;
    // fresh_s is the same shift applied to an empty register (sync restart).
    always_comb begin
        if (MSB_ORDER) begin
            shifted_s = {shreg_r[WIDTH-2:0], ser};
            fresh_s   = {{(WIDTH-1){1'b0}}, ser};
        end else begin
            shifted_s = {ser, shreg_r[WIDTH-1:1]};
            fresh_s   = {ser, {(WIDTH-1){1'b0}}};
        end
    end

    // Next shift register / bit counter; sync takes priority over completion
    // so a realigning edge never emits the discarded partial word.
    always_comb begin
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = bit_cnt_r;
        word_done_s = 1'b0;
        if (sync) begin
            if (shift_en) begin
                shreg_nxt_s = fresh_s;
                cnt_nxt_s   = ONE_CNT;
            end else begin
                shreg_nxt_s = {WIDTH{1'b0}};
                cnt_nxt_s   = {CW{1'b0}};
            end
        end else if (shift_en) begin
            if (bit_cnt_r == LAST_CNT) begin
                word_done_s = 1'b1;
                shreg_nxt_s = {WIDTH{1'b0}};
                cnt_nxt_s   = {CW{1'b0}};
            end else begin
                shreg_nxt_s = shifted_s;
                cnt_nxt_s   = bit_cnt_r + ONE_CNT;
            end
        end else begin
            shreg_nxt_s = shreg_r;
            cnt_nxt_s   = bit_cnt_r;
        end
    end

    // Framing FSM with registered busy; it tracks bit_cnt_r != 0 exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            shreg_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else begin
            shreg_r   <= shreg_nxt_s;
            bit_cnt_r <= cnt_nxt_s;
            case (state_r)
                IDLE: begin
                    if (shift_en) begin
                        state_r <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (word_done_s || (sync && !shift_en)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .word       (shifted_s),
        .word_done  (word_done_s),
        .dout_ready (dout_ready),
        .clr_overrun(clr_overrun),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule
